// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-drive signals of the two-requester ALU arbiter.
// slave is the arbiter's view; master is the requesters' and ALU's view.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        resp0_valid;
  logic        resp0_ready;
  logic [31:0] resp0_result;
  logic        resp0_fault;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp1_result;
  logic        resp1_fault;

  logic [4:0]  alu_op;
  logic [31:0] alu_in_a;
  logic [31:0] alu_in_b;
  logic [31:0] alu_out;
  logic        alu_fault;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_result, resp0_fault,
    output resp1_valid, resp1_result, resp1_fault,
    input  resp0_ready, resp1_ready,
    output alu_op, alu_in_a, alu_in_b,
    input  alu_out, alu_fault
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_result, resp0_fault,
    input  resp1_valid, resp1_result, resp1_fault,
    output resp0_ready, resp1_ready,
    input  alu_op, alu_in_a, alu_in_b,
    output alu_out, alu_fault
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one registered ALU between two requesters; response 2 cycles after accept.
// One transaction in flight; a stalled response blocks new accepts and holds the ALU operands.
module alu_arbiter (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic        owner;
  logic        last_grant;
  logic [4:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        resp_hs;
  logic        can_accept;
  logic        acc0;
  logic        acc1;
  logic [31:0] result;

  assign bus.alu_op   = op_q;
  assign bus.alu_in_a = a_q;
  assign bus.alu_in_b = b_q;

  always_comb begin
    state_nxt        = state;
    resp_hs          = 1'b0;
    can_accept       = 1'b0;
    acc0             = 1'b0;
    acc1             = 1'b0;
    result           = bus.alu_fault ? 32'd0 : bus.alu_out;
    bus.req0_ready   = 1'b0;
    bus.req1_ready   = 1'b0;
    bus.resp0_valid  = 1'b0;
    bus.resp0_result = 32'd0;
    bus.resp0_fault  = 1'b0;
    bus.resp1_valid  = 1'b0;
    bus.resp1_result = 32'd0;
    bus.resp1_fault  = 1'b0;

    if (!reset) begin
      // Only the owner's ready can retire the response; the other side is ignored.
      resp_hs    = (state == RESP) && (owner ? bus.resp1_ready : bus.resp0_ready);
      can_accept = (state == IDLE) || resp_hs;
      acc0       = can_accept && bus.req0_valid && (!bus.req1_valid || last_grant);
      acc1       = can_accept && bus.req1_valid && (!bus.req0_valid || !last_grant);
      bus.req0_ready = acc0;
      bus.req1_ready = acc1;

      if (state == RESP) begin
        if (owner) begin
          bus.resp1_valid  = 1'b1;
          bus.resp1_result = result;
          bus.resp1_fault  = bus.alu_fault;
        end else begin
          bus.resp0_valid  = 1'b1;
          bus.resp0_result = result;
          bus.resp0_fault  = bus.alu_fault;
        end
      end

      case (state)
        IDLE:    if (acc0 || acc1) state_nxt = EXEC;
        EXEC:    state_nxt = RESP;
        RESP:    if (resp_hs) state_nxt = (acc0 || acc1) ? EXEC : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= 5'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
    end else begin
      state <= state_nxt;
      if (acc0) begin
        op_q       <= bus.req0_op;
        a_q        <= bus.req0_a;
        b_q        <= bus.req0_b;
        owner      <= 1'b0;
        last_grant <= 1'b0;
      end else if (acc1) begin
        op_q       <= bus.req1_op;
        a_q        <= bus.req1_a;
        b_q        <= bus.req1_b;
        owner      <= 1'b1;
        last_grant <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: registered ALU model, transaction-level reference model,
// directed scenarios followed by randomized traffic with resets and backpressure.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if ifc();
  alu_arbiter dut (.clk(clk), .reset(reset), .bus(ifc));

  int errors = 0;
  int checks = 0;

  // Reference ALU: {fault, result}; unknown op codes fault.
  function automatic logic [32:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        f;
    r = 32'd0;
    f = 1'b0;
    case (op)
      5'b00000: r = a + b;
      5'b01000: r = a - b;
      5'b00111: r = a & b;
      5'b00110: r = a | b;
      5'b00100: r = a ^ b;
      5'b00001: r = a << b[4:0];
      5'b00101: r = a >> b[4:0];
      5'b10000: r = {31'd0, a == b};
      5'b10001: r = {31'd0, a != b};
      5'b10100: r = {31'd0, $signed(a) < $signed(b)};
      5'b10101: r = {31'd0, $signed(a) >= $signed(b)};
      5'b10110: r = {31'd0, a < b};
      5'b10111: r = {31'd0, a >= b};
      default:  f = 1'b1;
    endcase
    return {f, r};
  endfunction

  logic [32:0] alu_v;
  assign alu_v = alu_fn(ifc.alu_op, ifc.alu_in_a, ifc.alu_in_b);
  // A faulting ALU leaves garbage on its result; the arbiter must zero it.
  always @(posedge clk) begin
    ifc.alu_out   <= alu_v[32] ? 32'hDEADBEEF : alu_v[31:0];
    ifc.alu_fault <= alu_v[32];
  end

  // Reference model: at most one pending transaction, visible two cycles after accept.
  bit          m_busy = 1'b0;
  bit          m_owner = 1'b0;
  int          m_age = 0;
  logic [4:0]  m_op = 5'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  bit          m_last = 1'b1;

  logic        s_rdy0, s_rdy1, s_v0, s_v1, s_f0, s_f1;
  logic [31:0] s_r0, s_r1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, advances one clock.
  task automatic cycle();
    bit          vis, hs;
    int          win;
    logic [32:0] rv;
    logic [31:0] er;
    logic        ef;
    #3;
    s_rdy0 = ifc.req0_ready;   s_rdy1 = ifc.req1_ready;
    s_v0   = ifc.resp0_valid;  s_v1   = ifc.resp1_valid;
    s_r0   = ifc.resp0_result; s_r1   = ifc.resp1_result;
    s_f0   = ifc.resp0_fault;  s_f1   = ifc.resp1_fault;
    vis = 1'b0;
    hs  = 1'b0;
    win = -1;
    if (!reset) begin
      vis = m_busy && (m_age >= 2);
      if (vis) hs = m_owner ? ifc.resp1_ready : ifc.resp0_ready;
      if (!m_busy || hs) begin
        if (ifc.req0_valid && ifc.req1_valid) win = m_last ? 0 : 1;
        else if (ifc.req0_valid) win = 0;
        else if (ifc.req1_valid) win = 1;
      end
    end
    rv = alu_fn(m_op, m_a, m_b);
    er = rv[32] ? 32'd0 : rv[31:0];
    ef = rv[32];
    chk("req0_ready", s_rdy0, win == 0);
    chk("req1_ready", s_rdy1, win == 1);
    chk("resp0_valid", s_v0, vis && !m_owner);
    chk("resp1_valid", s_v1, vis && m_owner);
    chk("resp0_result", s_r0, (vis && !m_owner) ? er : 32'd0);
    chk("resp1_result", s_r1, (vis && m_owner) ? er : 32'd0);
    chk("resp0_fault", s_f0, vis && !m_owner && ef);
    chk("resp1_fault", s_f1, vis && m_owner && ef);
    if (m_busy && !reset) begin
      chk("alu_op", ifc.alu_op, m_op);
      chk("alu_in_a", ifc.alu_in_a, m_a);
      chk("alu_in_b", ifc.alu_in_b, m_b);
    end
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      if (hs) m_busy = 1'b0;
      else if (m_busy) m_age++;
      if (win >= 0) begin
        m_busy  = 1'b1;
        m_owner = (win == 1);
        m_age   = 1;
        m_last  = (win == 1);
        m_op    = (win == 1) ? ifc.req1_op : ifc.req0_op;
        m_a     = (win == 1) ? ifc.req1_a  : ifc.req0_a;
        m_b     = (win == 1) ? ifc.req1_b  : ifc.req0_b;
      end
    end
    #1;
  endtask

  task automatic drain();
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    ifc.resp0_ready = 1'b1;
    ifc.resp1_ready = 1'b1;
    repeat (3) cycle();
  endtask

  logic [4:0] op_tab [14] = '{5'b00000, 5'b01000, 5'b00111, 5'b00110, 5'b00100, 5'b00001, 5'b00101,
                              5'b10000, 5'b10001, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b01001};

  task automatic rand_payload(output logic [4:0] op, output logic [31:0] a, output logic [31:0] b);
    op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 13)];
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int q_grant [$];
  int q_time [$];

  initial begin
    ifc.req0_valid = 1'b0; ifc.req0_op = 5'd0; ifc.req0_a = 32'd0; ifc.req0_b = 32'd0;
    ifc.req1_valid = 1'b0; ifc.req1_op = 5'd0; ifc.req1_a = 32'd0; ifc.req1_b = 32'd0;
    ifc.resp0_ready = 1'b1;
    ifc.resp1_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset: outputs quiet even with requests pending.
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    repeat (2) cycle();
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    reset = 1'b0;
    chk("rst_alu_op", ifc.alu_op, 5'd0);
    chk("rst_alu_a", ifc.alu_in_a, 32'd0);
    chk("rst_alu_b", ifc.alu_in_b, 32'd0);
    cycle();

    // Single ADD: accept, one EXEC cycle, response two cycles after accept.
    ifc.req0_valid = 1'b1; ifc.req0_op = 5'b00000; ifc.req0_a = 32'd5; ifc.req0_b = 32'd7;
    cycle();
    chk("add_accept", s_rdy0, 1'b1);
    ifc.req0_valid = 1'b0;
    cycle();
    chk("add_exec_quiet", s_v0, 1'b0);
    cycle();
    chk("add_valid", s_v0, 1'b1);
    chk("add_result", s_r0, 32'd12);
    chk("add_fault", s_f0, 1'b0);
    chk("add_resp1_quiet", s_v1, 1'b0);
    drain();

    // Contention from reset release: strict alternation, accept every 2 cycles.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_op = 5'b01000; ifc.req0_a = 32'd10;         ifc.req0_b = 32'd3;
    ifc.req1_valid = 1'b1; ifc.req1_op = 5'b10100; ifc.req1_a = 32'hFFFFFFFF; ifc.req1_b = 32'd1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (s_rdy0) begin q_grant.push_back(0); q_time.push_back(i); end
      if (s_rdy1) begin q_grant.push_back(1); q_time.push_back(i); end
      if (s_v0) chk("cont_sub_result", s_r0, 32'd7);
      if (s_v1) chk("cont_blt_result", s_r1, 32'd1);
    end
    chk("cont_grant_count", q_grant.size(), 8);
    for (int k = 0; k < q_grant.size() && k < 8; k++) begin
      chk("cont_grant_order", q_grant[k], k % 2);
      chk("cont_grant_cycle", q_time[k], 2 * k);
    end
    drain();

    // Backpressure on requester 1; requester 0 waits; resp0_ready is ignored.
    ifc.resp1_ready = 1'b0;
    ifc.resp0_ready = 1'b1;
    ifc.req1_valid = 1'b1; ifc.req1_op = 5'b10000; ifc.req1_a = 32'h1234; ifc.req1_b = 32'h1234;
    cycle();
    chk("bp_accept1", s_rdy1, 1'b1);
    ifc.req1_valid = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_op = 5'b00000; ifc.req0_a = 32'd1; ifc.req0_b = 32'd2;
    cycle();
    chk("bp_exec_rdy0", s_rdy0, 1'b0);
    repeat (5) begin
      cycle();
      chk("bp_stall_valid1", s_v1, 1'b1);
      chk("bp_stall_result1", s_r1, 32'd1);
      chk("bp_stall_rdy0", s_rdy0, 1'b0);
      chk("bp_stall_valid0", s_v0, 1'b0);
    end
    ifc.resp1_ready = 1'b1;
    cycle();
    chk("bp_hs_valid1", s_v1, 1'b1);
    chk("bp_hs_rdy0", s_rdy0, 1'b1);
    ifc.req0_valid = 1'b0;
    repeat (2) cycle();
    chk("bp_next_valid0", s_v0, 1'b1);
    chk("bp_next_result0", s_r0, 32'd3);
    drain();

    // Invalid op: fault flag with zeroed result.
    ifc.req0_valid = 1'b1; ifc.req0_op = 5'b01001; ifc.req0_a = $urandom; ifc.req0_b = $urandom;
    cycle();
    chk("inv_accept", s_rdy0, 1'b1);
    ifc.req0_valid = 1'b0;
    repeat (2) cycle();
    chk("inv_valid", s_v0, 1'b1);
    chk("inv_fault", s_f0, 1'b1);
    chk("inv_result", s_r0, 32'd0);
    drain();

    // Reset during EXEC drops the transaction and restores the tie-break.
    ifc.req0_valid = 1'b1; ifc.req0_op = 5'b00000; ifc.req0_a = 32'd9; ifc.req0_b = 32'd9;
    cycle();
    chk("rmid_accept", s_rdy0, 1'b1);
    ifc.req0_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (4) begin
      cycle();
      chk("rmid_no_resp0", s_v0, 1'b0);
    end
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    cycle();
    chk("rmid_tie_rdy0", s_rdy0, 1'b1);
    chk("rmid_tie_rdy1", s_rdy1, 1'b0);
    drain();

    // Randomized traffic: requesters hold payload until accepted.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      ifc.resp0_ready = ($urandom_range(0, 9) < 7);
      ifc.resp1_ready = ($urandom_range(0, 9) < 7);
      if (!ifc.req0_valid && $urandom_range(0, 1) == 1) begin
        ifc.req0_valid = 1'b1;
        rand_payload(ifc.req0_op, ifc.req0_a, ifc.req0_b);
      end
      if (!ifc.req1_valid && $urandom_range(0, 1) == 1) begin
        ifc.req1_valid = 1'b1;
        rand_payload(ifc.req1_op, ifc.req1_a, ifc.req1_b);
      end
      cycle();
      if (s_rdy0) ifc.req0_valid = 1'b0;
      if (s_rdy1) ifc.req1_valid = 1'b0;
    end
    reset = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
